// File: rtl/isp_pkg.sv
// Shared definitions for the ISP RAM: loader FSM encoding, byte width and the
// address-width helper used by isp_ram and isp_ld_fsm.
package isp_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FILL  = 2'd1,
        LD_WRITE = 2'd2
    } ld_state_e;

    // ceil(log2(value)), never below 1 so a degenerate size still gets a real port.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/isp_ld_fsm.sv
// Byte-stream loader: packs little-endian bytes into words and issues one
// write per assembled word at a self-incrementing, wrapping word pointer.
module isp_ld_fsm
    import isp_pkg::*;
#(
    parameter  int RAM_DEPTH = 65536,
    parameter  int DATA_W    = 32,
    localparam int AW        = clog2(RAM_DEPTH),
    localparam int NB        = DATA_W / BYTE_W,
    localparam int IW        = clog2(NB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [AW-1:0]     ld_base,
    input  logic              ld_valid,
    input  logic [BYTE_W-1:0] ld_byte,
    output logic              ld_ready,
    input  logic              ld_end,
    output logic              ld_busy,
    output logic [AW:0]       ld_wcnt,
    output logic              ld_wrap,
    output logic              we,
    output logic [AW-1:0]     waddr,
    output logic [DATA_W-1:0] wdata
);

    ld_state_e         state;
    logic [AW-1:0]     ptr;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] wbuf;
    logic              end_pend;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LD_IDLE;
            ptr      <= '0;
            idx      <= '0;
            wbuf     <= '0;
            end_pend <= 1'b0;
            ld_wcnt  <= '0;
            ld_wrap  <= 1'b0;
        end else begin
            unique case (state)
                LD_IDLE: begin
                    if (ld_start) begin
                        state    <= LD_FILL;
                        ptr      <= ld_base;
                        idx      <= '0;
                        wbuf     <= '0;
                        end_pend <= 1'b0;
                        ld_wcnt  <= '0;
                        ld_wrap  <= 1'b0;
                    end
                end
                LD_FILL: begin
                    // ld_end wins over a byte offered in the same cycle.
                    if (ld_end) begin
                        if (idx != '0) begin
                            state    <= LD_WRITE;
                            end_pend <= 1'b1;
                        end else begin
                            state <= LD_IDLE;
                        end
                    end else if (ld_valid) begin
                        wbuf[idx*BYTE_W +: BYTE_W] <= ld_byte;
                        if (idx == IW'(NB - 1)) begin
                            state <= LD_WRITE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LD_WRITE: begin
                    if (ptr == AW'(RAM_DEPTH - 1)) begin
                        ptr     <= '0;
                        ld_wrap <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                    if (ld_wcnt != '1) ld_wcnt <= ld_wcnt + 1'b1;
                    idx      <= '0;
                    wbuf     <= '0;
                    end_pend <= 1'b0;
                    state    <= (end_pend || ld_end) ? LD_IDLE : LD_FILL;
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

    assign ld_ready = (state == LD_FILL) && !ld_end;
    assign ld_busy  = (state != LD_IDLE);
    assign we       = (state == LD_WRITE);
    assign waddr    = ptr;
    assign wdata    = wbuf;

endmodule

// File: rtl/isp_ram.sv
// Dual read-port RAM with a byte-stream loader write port; read-first on collision.
// Optional per-byte even parity storage and checking when ISP_PARITY_EN is defined.
module isp_ram
    import isp_pkg::*;
#(
    parameter  int RAM_DEPTH = 65536,
    parameter  int DATA_W    = 32,
    localparam int AW        = clog2(RAM_DEPTH),
    localparam int NB        = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [AW-1:0]     addra,
    output logic [DATA_W-1:0] douta,
    input  logic              enb,
    input  logic [AW-1:0]     addrb,
    output logic [DATA_W-1:0] doutb,
    input  logic              ld_start,
    input  logic [AW-1:0]     ld_base,
    input  logic              ld_valid,
    input  logic [BYTE_W-1:0] ld_byte,
    output logic              ld_ready,
    input  logic              ld_end,
    output logic              ld_busy,
    output logic [AW:0]       ld_wcnt,
    output logic              ld_wrap,
    output logic              perra,
    output logic              perrb
);

    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem [RAM_DEPTH];

    isp_ld_fsm #(
        .RAM_DEPTH (RAM_DEPTH),
        .DATA_W    (DATA_W)
    ) u_ld_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_valid (ld_valid),
        .ld_byte  (ld_byte),
        .ld_ready (ld_ready),
        .ld_end   (ld_end),
        .ld_busy  (ld_busy),
        .ld_wcnt  (ld_wcnt),
        .ld_wrap  (ld_wrap),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata)
    );

    // NOTE: the array has no reset branch; a reset would turn the block RAM
    // into flops and is not needed since contents are defined only once loaded.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Same-edge write and read both sample mem before update, giving read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            douta <= '0;
            doutb <= '0;
        end else begin
            if (ena) douta <= mem[addra];
            if (enb) doutb <= mem[addrb];
        end
    end

`ifdef ISP_PARITY_EN
    logic [NB-1:0] par_mem [RAM_DEPTH];

    function automatic logic [NB-1:0] lane_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^w[i*BYTE_W +: BYTE_W];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (we) par_mem[waddr] <= lane_par(wdata);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perra <= 1'b0;
            perrb <= 1'b0;
        end else begin
            if (ena) perra <= |(lane_par(mem[addra]) ^ par_mem[addra]);
            if (enb) perrb <= |(lane_par(mem[addrb]) ^ par_mem[addrb]);
        end
    end
`else
    assign perra = 1'b0;
    assign perrb = 1'b0;
`endif

endmodule

// File: tb/tb_isp_ram.sv
// Self-checking bench for isp_ram: directed loader/read scenarios plus random
// sessions, all checked against an array-based model of the loaded words.
module tb_isp_ram;
    import isp_pkg::*;

    localparam int DEPTH = 24;
    localparam int DW    = 32;
    localparam int AW    = clog2(DEPTH);
    localparam int NB    = DW / 8;
    localparam int WMAX  = (1 << (AW + 1)) - 1;

    logic          clk;
    logic          rst_n;
    logic          ena, enb;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] douta, doutb;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_ready;
    logic          ld_end;
    logic          ld_busy;
    logic [AW:0]   ld_wcnt;
    logic          ld_wrap;
    logic          perra, perrb;

    isp_ram #(.RAM_DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .addra(addra), .douta(douta),
        .enb(enb), .addrb(addrb), .doutb(doutb),
        .ld_start(ld_start), .ld_base(ld_base),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
        .ld_end(ld_end), .ld_busy(ld_busy), .ld_wcnt(ld_wcnt),
        .ld_wrap(ld_wrap), .perra(perra), .perrb(perrb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: word contents per address plus a "known" flag.
    logic [DW-1:0] model_mem [DEPTH];
    bit            known     [DEPTH];
    logic [7:0]    sess_bytes[$];
    int            sess_base;
    logic [DW-1:0] last_a;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    task automatic start_session(input int base);
        @(negedge clk);
        ld_start = 1'b1;
        ld_base  = AW'(base);
        @(negedge clk);
        ld_start = 1'b0;
        sess_base = base;
        sess_bytes.delete();
    endtask

    // Offers one byte, waiting out WRITE cycles; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        if ($urandom_range(3) == 0) begin
            ld_valid = 1'b0;
            @(negedge clk);
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        for (int i = 0; i < 8 && !done; i++) begin
            if (ld_ready) done = 1'b1;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        if (done) sess_bytes.push_back(b);
        else timeout_fail("ld_ready wait");
    endtask

    // Words a session must produce, derived only from the byte list and base.
    task automatic commit_model(output int nw);
        logic [DW-1:0] word;
        nw = (sess_bytes.size() + NB - 1) / NB;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int l = 0; l < NB; l++)
                if (w * NB + l < sess_bytes.size()) word[l*8 +: 8] = sess_bytes[w*NB + l];
            model_mem[(sess_base + w) % DEPTH] = word;
            known[(sess_base + w) % DEPTH] = 1'b1;
        end
    endtask

    task automatic end_session(input bit junk);
        int  nw;
        bit  idle;
        ld_end = 1'b1;
        if (junk) begin
            ld_valid = 1'b1;
            ld_byte  = 8'($urandom);
        end
        @(negedge clk);
        ld_end   = 1'b0;
        ld_valid = 1'b0;
        idle = 1'b0;
        for (int i = 0; i < 6 && !idle; i++) begin
            if (!ld_busy) idle = 1'b1;
            else @(negedge clk);
        end
        if (!idle) timeout_fail("ld_busy drop");
        commit_model(nw);
        check("wcnt", 64'(ld_wcnt), 64'((nw > WMAX) ? WMAX : nw));
        check("wrap", 64'(ld_wrap), 64'((nw > 0) && (sess_base + nw >= DEPTH)));
        check("busy_end", 64'(ld_busy), 64'(0));
    endtask

    task automatic rd_ab(input int aa, input bit use_a, input int bb, input bit use_b);
        @(negedge clk);
        ena = use_a; addra = AW'(aa);
        enb = use_b; addrb = AW'(bb);
        @(negedge clk);
        ena = 1'b0; enb = 1'b0;
        if (use_a) begin
            check($sformatf("douta[%0d]", aa), 64'(douta), 64'(model_mem[aa]));
            check("perra", 64'(perra), 64'(0));
            last_a = model_mem[aa];
        end
        if (use_b) begin
            check($sformatf("doutb[%0d]", bb), 64'(doutb), 64'(model_mem[bb]));
            check("perrb", 64'(perrb), 64'(0));
        end
    endtask

    task automatic load_bytes(input int base, input logic [7:0] bytes[$], input bit junk);
        start_session(base);
        foreach (bytes[i]) send_byte(bytes[i]);
        end_session(junk);
    endtask

    initial begin
        logic [7:0] q[$];
        int         base, n, aa, bb;

        for (int i = 0; i < DEPTH; i++) begin
            known[i] = 1'b0;
            model_mem[i] = '0;
        end
        rst_n = 1'b0; ena = 1'b0; enb = 1'b0; addra = '0; addrb = '0;
        ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_byte = '0; ld_end = 1'b0;
        last_a = '0;

        #2;
        check("rst_douta", 64'(douta), 64'(0));
        check("rst_doutb", 64'(doutb), 64'(0));
        check("rst_perra", 64'(perra), 64'(0));
        check("rst_perrb", 64'(perrb), 64'(0));
        check("rst_wcnt", 64'(ld_wcnt), 64'(0));
        check("rst_wrap", 64'(ld_wrap), 64'(0));
        check("rst_busy", 64'(ld_busy), 64'(0));
        check("rst_ready", 64'(ld_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Two full words at 0x10.
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load_bytes(16, q, 1'b0);
        check("const_w16", 64'(model_mem[16]), 64'(32'h44332211));
        check("const_w17", 64'(model_mem[17]), 64'(32'h88776655));
        rd_ab(16, 1'b1, 17, 1'b1);

        // Partial flush pads upper lanes with zero.
        q = '{8'hAA, 8'hBB};
        load_bytes(3, q, 1'b0);
        check("const_w3", 64'(model_mem[3]), 64'(32'h0000BBAA));
        rd_ab(3, 1'b1, 3, 1'b1);

        // ld_end with no bytes pending writes nothing.
        q = '{8'h04, 8'h03, 8'h02, 8'h01};
        load_bytes(9, q, 1'b0);
        q.delete();
        load_bytes(9, q, 1'b0);
        rd_ab(9, 1'b1, 16, 1'b1);

        // Read latency and hold on port A.
        q = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
        load_bytes(5, q, 1'b0);
        rd_ab(16, 1'b1, 0, 1'b0);
        @(negedge clk);
        ena = 1'b1; addra = AW'(5);
        #1 check("lat_before_edge", 64'(douta), 64'(last_a));
        @(negedge clk);
        check("lat_one_cycle", 64'(douta), 64'(model_mem[5]));
        ena = 1'b0; addra = AW'(16);
        @(negedge clk);
        check("lat_hold", 64'(douta), 64'(model_mem[5]));

        // Read-first collision at address 7.
        q = '{8'h01, 8'h23, 8'h45, 8'h67};
        load_bytes(7, q, 1'b0);
        start_session(7);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("ready_in_write", 64'(ld_ready), 64'(0));
        ena = 1'b1; addra = AW'(7);
        @(negedge clk);
        ena = 1'b0;
        check("collide_old", 64'(douta), 64'(model_mem[7]));
        end_session(1'b0);
        check("collide_new_model", 64'(model_mem[7]), 64'(32'hDEADBEEF));
        rd_ab(7, 1'b1, 7, 1'b1);

        // ld_end arriving while the FSM is in WRITE still completes that word.
        q = '{8'h10, 8'h20, 8'h30, 8'h40};
        load_bytes(12, q, 1'b1);
        rd_ab(12, 1'b1, 12, 1'b1);

        // ld_start during FILL is ignored; ld_end in IDLE is ignored.
        start_session(14);
        send_byte(8'h9A); send_byte(8'h9B);
        @(negedge clk);
        ld_start = 1'b1; ld_base = AW'(0);
        @(negedge clk);
        ld_start = 1'b0;
        send_byte(8'h9C); send_byte(8'h9D);
        end_session(1'b1);
        rd_ab(14, 1'b1, 0, 1'b0);
        @(negedge clk);
        ld_end = 1'b1;
        @(negedge clk);
        ld_end = 1'b0;
        @(negedge clk);
        check("end_in_idle_busy", 64'(ld_busy), 64'(0));
        check("end_in_idle_wcnt", 64'(ld_wcnt), 64'(1));

        // Pointer wrap from the last word back to 0.
        q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        load_bytes(DEPTH - 1, q, 1'b0);
        rd_ab(DEPTH - 1, 1'b1, 0, 1'b1);

        // Random sessions and dual-port reads.
        for (int s = 0; s < 8; s++) begin
            base = $urandom_range(DEPTH - 1);
            n    = $urandom_range(14);
            q.delete();
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            load_bytes(base, q, 1'($urandom_range(1)));
        end
        for (int r = 0; r < 20; r++) begin
            aa = $urandom_range(DEPTH - 1);
            bb = $urandom_range(DEPTH - 1);
            rd_ab(aa, known[aa], bb, known[bb]);
        end

        // Long session: wcnt saturates, pointer wraps repeatedly.
        q.delete();
        for (int k = 0; k < (WMAX + 7) * NB; k++) q.push_back(8'($urandom));
        load_bytes(0, q, 1'b0);
        for (int i = 0; i < DEPTH; i += 2) rd_ab(i, 1'b1, i + 1, 1'b1);

        // Asynchronous reset mid-FILL.
        rd_ab(4, 1'b1, 5, 1'b1);
        start_session(2);
        send_byte(8'h77); send_byte(8'h66);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(ld_busy), 64'(0));
        check("arst_ready", 64'(ld_ready), 64'(0));
        check("arst_douta", 64'(douta), 64'(0));
        check("arst_doutb", 64'(doutb), 64'(0));
        check("arst_wcnt", 64'(ld_wcnt), 64'(0));
        check("arst_wrap", 64'(ld_wrap), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while the WRITE cycle is pending leaves other words intact.
        start_session(20);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        rst_n = 1'b0;
        #1 check("wr_rst_busy", 64'(ld_busy), 64'(0));
        known[20] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) if (known[i]) rd_ab(i, 1'b1, (i + 3) % DEPTH, known[(i + 3) % DEPTH]);

`ifdef ISP_PARITY_EN
        dut.par_mem[5] = dut.par_mem[5] ^ 4'b0001;
        @(negedge clk);
        ena = 1'b1; addra = AW'(5);
        @(negedge clk);
        ena = 1'b0;
        check("par_flip_perra", 64'(perra), 64'(1));
        @(negedge clk);
        check("par_hold_perra", 64'(perra), 64'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
